// File: rtl/screen_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : screen_sequencer_if
//  Description : Signal bundle between the TicTacToe screen sequencer and
//                its surroundings (button, game logic, VGA timing, divider).
//  Revision    : 1.0 - initial release
// ============================================================================
interface screen_sequencer_if;
    // Inputs to the sequencer
    logic       start;      // raw pushbutton, asynchronous
    logic       game_over;  // level from game logic, clk_100MHz domain
    logic [1:0] winner;     // 01 X, 10 O, 11 draw, 00 none
    logic       vsync;      // frame pulse from the 50 MHz VGA domain
    logic       clk1Hz;     // 1 Hz square wave

    // Outputs from the sequencer
    logic       ceSS;       // start-screen enable
    logic       cePS;       // play-screen enable
    logic       ceWS;       // winner-screen enable
    logic       game_rst;   // one-cycle game clear on PLAY entry
    logic [1:0] winner_q;   // latched winner
    logic [1:0] screen;     // 00 START, 01 PLAY, 10 WIN

    // Environment side: drives stimuli, observes enables
    modport master (
        output start, game_over, winner, vsync, clk1Hz,
        input  ceSS, cePS, ceWS, game_rst, winner_q, screen
    );

    // Sequencer side
    modport slave (
        input  start, game_over, winner, vsync, clk1Hz,
        output ceSS, cePS, ceWS, game_rst, winner_q, screen
    );
endinterface
`default_nettype wire

// File: rtl/screen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : screen_sequencer
//  Description : START / PLAY / WIN screen sequencer for the TicTacToe VGA
//                display. Screen changes are deferred to the next frame
//                boundary (vsync rising edge) so no frame is torn.
//  Revision    : 1.0 - initial release
// ============================================================================
module screen_sequencer #(
    parameter int WIN_SECS = 5,   // winner screen duration in seconds (1..15)
    parameter int CNT_W    = 4    // width of the seconds counter
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    screen_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_PLAY  = 2'b01,
        ST_WIN   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] c_SEC_LAST = CNT_W'(WIN_SECS - 1);

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizer, delay flop, registered edge
    // ------------------------------------------------------------------
    logic r_start_s1, r_start_s2, r_start_d, r_start_edge;
    logic r_vs_s1,    r_vs_s2,    r_vs_d,    r_frame_tick;
    logic r_sec_s1,   r_sec_s2,   r_sec_d,   r_sec_tick;

    // Start button: the whole chain presets to 1 so a button held through
    // reset is treated as already pressed and must be seen low before the
    // first press can register.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_start_s1   <= 1'b1;
            r_start_s2   <= 1'b1;
            r_start_d    <= 1'b1;
            r_start_edge <= 1'b0;
        end else begin
            r_start_s1   <= bus.start;
            r_start_s2   <= r_start_s1;
            r_start_d    <= r_start_s2;
            r_start_edge <= r_start_s2 & ~r_start_d;
        end
    end

    // vsync crosses from the VGA domain; its rising edge marks a frame boundary
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_vs_s1      <= 1'b0;
            r_vs_s2      <= 1'b0;
            r_vs_d       <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_vs_s1      <= bus.vsync;
            r_vs_s2      <= r_vs_s1;
            r_vs_d       <= r_vs_s2;
            r_frame_tick <= r_vs_s2 & ~r_vs_d;
        end
    end

    // 1 Hz divider output turned into a one-cycle seconds tick
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_sec_s1   <= 1'b0;
            r_sec_s2   <= 1'b0;
            r_sec_d    <= 1'b0;
            r_sec_tick <= 1'b0;
        end else begin
            r_sec_s1   <= bus.clk1Hz;
            r_sec_s2   <= r_sec_s1;
            r_sec_d    <= r_sec_s2;
            r_sec_tick <= r_sec_s2 & ~r_sec_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           r_target;
    logic             r_pending;
    logic [CNT_W-1:0] r_secs;
    logic             r_game_rst;
    logic [1:0]       r_winner_q;
    logic             r_ce_ss, r_ce_ps, r_ce_ws;

    state_t w_next;
    state_t w_req_tgt;
    logic   w_req;        // a screen change is wanted this cycle
    logic   w_accept;     // request is taken (nothing already pending)
    logic   w_switch;     // state changes at the end of this cycle
    logic   w_timeout;    // winner screen has been shown long enough
    logic   w_enter_play;
    logic   w_enter_win;

    // Next-state logic: raise requests per screen, commit them on a frame tick
    always_comb begin
        w_req     = 1'b0;
        w_req_tgt = r_state;
        w_timeout = 1'b0;
        w_next    = r_state;

        unique case (r_state)
            ST_START: begin
                w_req     = r_start_edge;
                w_req_tgt = ST_PLAY;
            end
            ST_PLAY: begin
                // game logic is still being cleared during the game_rst cycle
                w_req     = bus.game_over & ~r_game_rst;
                w_req_tgt = ST_WIN;
            end
            ST_WIN: begin
                w_timeout = r_sec_tick & (r_secs == c_SEC_LAST);
                w_req     = r_start_edge | w_timeout;
                w_req_tgt = ST_START;
            end
            default: begin
                w_req     = 1'b0;
                w_req_tgt = ST_START;
            end
        endcase

        w_accept = w_req & ~r_pending;
        w_switch = r_frame_tick & (r_pending | w_req);

        if (w_switch) begin
            w_next = r_pending ? r_target : w_req_tgt;
        end
        if ((r_state != ST_START) && (r_state != ST_PLAY) && (r_state != ST_WIN)) begin
            w_next = ST_START;
        end

        w_enter_play = w_switch & (w_next == ST_PLAY) & (r_state != ST_PLAY);
        w_enter_win  = w_switch & (w_next == ST_WIN)  & (r_state != ST_WIN);
    end

    // State register with one-hot screen enables registered alongside
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state <= ST_START;
            r_ce_ss <= 1'b1;
            r_ce_ps <= 1'b0;
            r_ce_ws <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ce_ss <= (w_next == ST_START);
            r_ce_ps <= (w_next == ST_PLAY);
            r_ce_ws <= (w_next == ST_WIN);
        end
    end

    // Pending request: first request wins and is held until the frame tick
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_target  <= ST_START;
        end else if (w_switch) begin
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_pending <= 1'b1;
            r_target  <= w_req_tgt;
        end
    end

    // One-cycle game clear on the first PLAY cycle
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_game_rst <= 1'b0;
        end else begin
            r_game_rst <= w_enter_play;
        end
    end

    // Winner latch: cleared on PLAY entry, captured with the game-over request
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_winner_q <= 2'b00;
        end else if (w_enter_play) begin
            r_winner_q <= 2'b00;
        end else if ((r_state == ST_PLAY) && w_accept) begin
            r_winner_q <= bus.winner;
        end
    end

    // Seconds counter for the winner screen, saturating at the last second
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_secs <= '0;
        end else if (w_enter_win) begin
            r_secs <= '0;
        end else if ((r_state == ST_WIN) && r_sec_tick && (r_secs != c_SEC_LAST)) begin
            r_secs <= r_secs + 1'b1;
        end
    end

    assign bus.ceSS     = r_ce_ss;
    assign bus.cePS     = r_ce_ps;
    assign bus.ceWS     = r_ce_ws;
    assign bus.game_rst = r_game_rst;
    assign bus.winner_q = r_winner_q;
    assign bus.screen   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_screen_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_screen_sequencer
//  Description : Self-checking bench for screen_sequencer. A screen-level
//                model derived from input sample histories predicts every
//                output each cycle; directed scenarios add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_sequencer;

    localparam int WIN_SECS = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    screen_sequencer_if bus();

    screen_sequencer #(
        .WIN_SECS (WIN_SECS),
        .CNT_W    (4)
    ) dut (
        .clk_100MHz (clk),
        .reset      (rst),
        .bus        (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Input histories hold the last four samples of each
    // input (bit 0 newest); a conditioned pulse is visible in the cycle after
    // the input was first seen high two samples earlier.
    // ------------------------------------------------------------------
    int         m_scr;      // 0 START, 1 PLAY, 2 WIN
    bit         m_pend;
    int         m_tgt;
    int         m_ticks;    // seconds ticks seen since WIN entry
    bit         m_first;    // first cycle of PLAY
    logic [1:0] m_wq;
    logic [3:0] hs, hv, hc;

    task automatic model_reset();
        m_scr   = 0;
        m_pend  = 0;
        m_tgt   = 0;
        m_ticks = 0;
        m_first = 0;
        m_wq    = 2'b00;
        hs      = 4'b1111;  // button counts as pressed until seen low
        hv      = 4'b0000;
        hc      = 4'b0000;
    endtask

    task automatic model_step();
        bit se, ft, st, req;
        int rt, nxt;
        if (rst) begin
            model_reset();
            return;
        end
        se  = hs[2] && !hs[3];
        ft  = hv[2] && !hv[3];
        st  = hc[2] && !hc[3];
        req = 0;
        rt  = m_scr;
        case (m_scr)
            0: begin
                req = se;
                rt  = 1;
            end
            1: begin
                req = bus.game_over && !m_first;
                rt  = 2;
                if (req && !m_pend) m_wq = bus.winner;
            end
            default: begin
                req = se || (st && m_ticks >= WIN_SECS - 1);
                rt  = 0;
            end
        endcase
        if (m_scr == 2 && st) m_ticks++;
        m_first = 0;
        if (ft && (m_pend || req)) begin
            nxt    = m_pend ? m_tgt : rt;
            m_pend = 0;
            m_scr  = nxt;
            if (nxt == 1) begin
                m_first = 1;
                m_wq    = 2'b00;
            end
            if (nxt == 2) m_ticks = 0;
        end else if (req && !m_pend) begin
            m_pend = 1;
            m_tgt  = rt;
        end
        hs = {hs[2:0], bus.start};
        hv = {hv[2:0], bus.vsync};
        hc = {hc[2:0], bus.clk1Hz};
    endtask

    // Every cycle, compare all outputs against the model
    always @(negedge clk) begin
        chk("screen",   int'(bus.screen),   m_scr);
        chk("ceSS",     int'(bus.ceSS),     int'(m_scr == 0));
        chk("cePS",     int'(bus.cePS),     int'(m_scr == 1));
        chk("ceWS",     int'(bus.ceWS),     int'(m_scr == 2));
        chk("game_rst", int'(bus.game_rst), int'(m_first));
        chk("winner_q", int'(bus.winner_q), int'(m_wq));
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Literal expectation applied to both the DUT and the model
    task automatic lit(input string name, input int dut_v, input int mdl_v, input int exp);
        chk({name, "_dut"},   dut_v, exp);
        chk({name, "_model"}, mdl_v, exp);
    endtask

    task automatic vsync_pulse_then(input int hold);
        bus.vsync = 1'b1;
        repeat (hold) tick();
    endtask

    task automatic sec_pulse();
        bus.clk1Hz = 1'b1;
        repeat (4) tick();
        bus.clk1Hz = 1'b0;
        repeat (4) tick();
    endtask

    int cs, cv, cc, cg;

    initial begin
        model_reset();
        bus.start     = 1'b1;
        bus.vsync     = 1'b0;
        bus.clk1Hz    = 1'b0;
        bus.game_over = 1'b0;
        bus.winner    = 2'b00;
        repeat (4) tick();
        rst = 1'b0;

        // Button held through reset must not start a game
        vsync_pulse_then(4);
        bus.vsync = 1'b0;
        repeat (20) tick();
        lit("held_start", int'(bus.screen), m_scr, 0);

        // Release, press for 10 cycles, frame boundary 200 cycles later
        bus.start = 1'b0;
        repeat (5) tick();
        bus.start = 1'b1;
        repeat (10) tick();
        bus.start = 1'b0;
        repeat (200) tick();
        lit("wait_frame", int'(bus.screen), m_scr, 0);
        vsync_pulse_then(3);
        lit("pre_switch", int'(bus.screen), m_scr, 0);
        tick();
        lit("play_entry", int'(bus.cePS), int'(m_scr == 1), 1);
        lit("game_rst_hi", int'(bus.game_rst), int'(m_first), 1);
        lit("wq_cleared", int'(bus.winner_q), int'(m_wq), 0);
        tick();
        lit("game_rst_lo", int'(bus.game_rst), int'(m_first), 0);
        bus.vsync = 1'b0;
        repeat (10) tick();

        // PLAY -> WIN with O winning; later winner changes are ignored
        bus.winner    = 2'b10;
        bus.game_over = 1'b1;
        repeat (10) tick();
        lit("play_pending", int'(bus.screen), m_scr, 1);
        vsync_pulse_then(4);
        lit("win_entry", int'(bus.ceWS), int'(m_scr == 2), 1);
        lit("win_latched", int'(bus.winner_q), int'(m_wq), 2);
        bus.vsync  = 1'b0;
        bus.winner = 2'b01;
        repeat (10) tick();
        lit("win_hold", int'(bus.winner_q), int'(m_wq), 2);
        bus.game_over = 1'b0;

        // Four seconds is not enough; the fifth returns to START
        repeat (4) sec_pulse();
        vsync_pulse_then(4);
        bus.vsync = 1'b0;
        repeat (10) tick();
        lit("four_secs", int'(bus.screen), m_scr, 2);
        sec_pulse();
        vsync_pulse_then(4);
        lit("five_secs", int'(bus.screen), m_scr, 0);
        bus.vsync = 1'b0;
        repeat (10) tick();

        // Start edge coinciding with the frame tick switches on that tick
        bus.start = 1'b1;
        vsync_pulse_then(4);
        lit("coincide_play", int'(bus.screen), m_scr, 1);
        bus.start = 1'b0;
        bus.vsync = 1'b0;
        repeat (10) tick();

        // Draw -> WIN, two seconds, then an early skip by the button
        bus.winner    = 2'b11;
        bus.game_over = 1'b1;
        repeat (3) tick();
        vsync_pulse_then(4);
        lit("draw_win", int'(bus.winner_q), int'(m_wq), 3);
        bus.vsync     = 1'b0;
        bus.game_over = 1'b0;
        repeat (2) sec_pulse();
        bus.start = 1'b1;
        repeat (10) tick();
        bus.start = 1'b0;
        repeat (20) tick();
        lit("skip_pending", int'(bus.screen), m_scr, 2);
        vsync_pulse_then(4);
        lit("skip_done", int'(bus.screen), m_scr, 0);
        bus.vsync = 1'b0;
        repeat (10) tick();

        // Enter PLAY, then reset while a PLAY->WIN request is pending
        bus.start = 1'b1;
        vsync_pulse_then(4);
        bus.start = 1'b0;
        bus.vsync = 1'b0;
        repeat (10) tick();
        bus.winner    = 2'b01;
        bus.game_over = 1'b1;
        repeat (10) tick();
        lit("pre_reset_wq", int'(bus.winner_q), int'(m_wq), 1);
        rst = 1'b1;
        model_reset();
        #1;
        lit("reset_ceSS", int'(bus.ceSS), int'(m_scr == 0), 1);
        lit("reset_wq", int'(bus.winner_q), int'(m_wq), 0);
        repeat (2) tick();
        rst = 1'b0;
        vsync_pulse_then(4);
        bus.vsync = 1'b0;
        repeat (10) tick();
        lit("reset_abort", int'(bus.screen), m_scr, 0);
        bus.game_over = 1'b0;

        // Randomized traffic with occasional mid-operation resets
        cs = 5; cv = 20; cc = 7; cg = 30;
        for (int i = 0; i < 4000; i++) begin
            if (cs == 0) begin
                bus.start = ~bus.start;
                cs = int'($urandom_range(40, 1));
            end else cs--;
            if (cv == 0) begin
                bus.vsync = ~bus.vsync;
                cv = bus.vsync ? 3 : int'($urandom_range(60, 8));
            end else cv--;
            if (cc == 0) begin
                bus.clk1Hz = ~bus.clk1Hz;
                cc = int'($urandom_range(12, 2));
            end else cc--;
            if (cg == 0) begin
                bus.game_over = ~bus.game_over;
                bus.winner    = 2'($urandom_range(3, 0));
                cg = int'($urandom_range(50, 1));
            end else cg--;
            if ($urandom_range(1499, 0) == 0) begin
                rst = 1'b1;
                model_reset();
            end else if (rst) begin
                rst = 1'b0;
            end
            tick();
        end
        rst = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
